// File: rtl/fir_interpolator_x2.sv
// 2x polyphase FIR interpolator, one serial MAC, 16-bit in/out, round-half-up, saturate.
// Latency: out_valid rises TAPS+2 edges after input accept and TAPS+2 edges after the phase-0 handshake.
// Backpressure: one sample in flight; in_ready only in IDLE; OUT holds sample_out until out_ready.
module fir_interpolator_x2 #(
    parameter int NUM_COEF = 32        // even; two phases of NUM_COEF/2 taps each
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] sample_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] coef [NUM_COEF],
    output logic signed [15:0] sample_out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int TAPS = NUM_COEF / 2;
    localparam int TW   = $clog2(TAPS);
    localparam int KW   = $clog2(TAPS + 1);
    // 32-bit products summed over up to a few hundred taps fit with margin
    localparam int AW   = 40;

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t             state;
    logic signed [15:0] x [TAPS];
    logic [KW-1:0]      k;
    logic               phase;
    logic signed [AW-1:0] acc;
    // Registered product: the multiplier output is accumulated one cycle later,
    // so MAC runs TAPS+1 cycles with the last one only draining the product.
    logic signed [31:0] prod;

    logic [TW-1:0]        k_tap;
    logic signed [15:0]   coef_sel;
    logic signed [15:0]   x_sel;
    logic signed [AW-1:0] rnd;
    logic signed [15:0]   y_sat;

    // Operand select for the current tap, and rounding/saturation of the finished sum
    always_comb begin
        k_tap    = (k < KW'(TAPS)) ? k[TW-1:0] : '0;
        coef_sel = coef[{k_tap, phase}];
        x_sel    = x[k_tap];
        rnd      = (acc + AW'(8192)) >>> 14;
        y_sat    = rnd[15:0];
        if (rnd > AW'(32767)) begin
            y_sat = 16'h7fff;
        end else if (rnd < AW'(-32768)) begin
            y_sat = 16'h8000;
        end
    end

    // Control FSM, delay line and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            sample_out <= '0;
            acc        <= '0;
            prod       <= '0;
            phase      <= 1'b0;
            k          <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x[0] <= sample_in;
                        for (int i = 1; i < TAPS; i++) begin
                            x[i] <= x[i-1];
                        end
                        phase    <= 1'b0;
                        k        <= '0;
                        acc      <= '0;
                        prod     <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc  <= acc + AW'(prod);
                    prod <= 32'(coef_sel) * 32'(x_sel);
                    k    <= k + KW'(1);
                    if (k == KW'(TAPS)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    sample_out <= y_sat;
                    out_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!phase) begin
                            phase <= 1'b1;
                            k     <= '0;
                            acc   <= '0;
                            prod  <= '0;
                            state <= MAC;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interpolator_x2.sv
// Self-checking bench for fir_interpolator_x2 against a direct-form arithmetic model.
// Latency: checks TAPS+2 edge latency for both phases.
// Backpressure: exercises fixed, random and stalled out_ready.
module tb_fir_interpolator_x2;

    localparam int NUM_COEF = 32;
    localparam int TAPS     = NUM_COEF / 2;
    localparam int LAT      = TAPS + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] sample_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] coef [NUM_COEF];
    logic signed [15:0] sample_out;
    logic               out_valid;
    logic               out_ready = 1'b1;

    always #5 clk = ~clk;

    fir_interpolator_x2 #(.NUM_COEF(NUM_COEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coef       (coef),
        .sample_out (sample_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int     xm [TAPS];
    longint exp_q [$];
    longint got_q [$];

    function automatic longint ref_out(input int p);
        longint a;
        a = 0;
        for (int i = 0; i < TAPS; i++) begin
            a += longint'(coef[2*i+p]) * longint'(xm[i]);
        end
        a = (a + 64'sd8192) >>> 14;
        if (a > 32767) a = 32767;
        else if (a < -32768) a = -32768;
        return a;
    endfunction

    function automatic void model_push(input int s);
        for (int i = TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
        xm[0] = s;
        exp_q.push_back(ref_out(0));
        exp_q.push_back(ref_out(1));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) xm[i] = 0;
        exp_q.delete();
    endfunction

    // ---------------- cycle count, out_ready driver, monitor ----------------
    int cyc        = 0;
    int acc_cyc    = 0;
    int hs_cyc     = 0;
    int hs_cnt     = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit mon_phase  = 1'b0;
    bit prev_vld   = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_phase = 1'b0;
            prev_vld  = 1'b0;
        end else begin
            if (out_valid && !prev_vld) begin
                if (!mon_phase) check("lat_phase0", cyc - acc_cyc, LAT);
                else            check("lat_phase1", cyc - hs_cyc, LAT);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    check("out_dat", sample_out, exp_q.pop_front());
                end
                got_q.push_back(longint'(sample_out));
                hs_cnt++;
                hs_cyc    = cyc + 1;
                mon_phase = ~mon_phase;
            end
            prev_vld = out_valid;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy",  in_ready,   1);
        check("rst_out_vld", out_valid,  0);
        check("rst_dat",     sample_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int s);
        int n;
        n = 0;
        sample_in = 16'(s);
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_push(s);
            #1;
            acc_cyc  = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_impulse();
        for (int i = 0; i < 20; i++) send(i == 0 ? 16384 : 0);
        wait_drain();
    endtask

    // Outputs 1..32 (coef[i]=i+1 scaled by 16384/16384), then zeros
    task automatic check_impulse(input string tag);
        check({tag, "_cnt"}, got_q.size(), 40);
        for (int i = 0; i < got_q.size(); i++) begin
            check(tag, got_q[i], (i < 32) ? i + 1 : 0);
        end
    endtask

    task automatic stall_once();
        int n;
        logic signed [15:0] held;
        n = 0;
        while (hs_cnt < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ready_mode = 2;
        n = 0;
        while (!(out_valid && !out_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(out_valid && !out_ready)) begin
            check("stall_timeout", out_valid, 1);
        end else begin
            held = sample_out;
            repeat (10) begin
                @(negedge clk);
                check("bp_vld",    out_valid,  1);
                check("bp_dat",    sample_out, held);
                check("bp_in_rdy", in_ready,   0);
            end
        end
        ready_mode = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int seen;
        int n;
        int rexp [6];
        logic signed [15:0] r;

        for (int i = 0; i < NUM_COEF; i++) coef[i] = '0;

        // reset, then idle with out_ready high: nothing may come out
        do_reset();
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("idle_no_out", seen, 0);
        check("idle_in_rdy", in_ready, 1);

        // impulse response
        for (int i = 0; i < NUM_COEF; i++) coef[i] = 16'(i + 1);
        do_reset();
        got_q.delete();
        run_impulse();
        check_impulse("imp");

        // same sequence with a 10-cycle output stall and in_valid held during it
        do_reset();
        got_q.delete();
        hs_cnt = 0;
        fork
            run_impulse();
            stall_once();
        join
        check_impulse("bp_seq");

        // reset during phase-1 MAC, then rerun the impulse
        do_reset();
        hs_cnt = 0;
        send(16384);
        n = 0;
        while (hs_cnt < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_hs_seen", hs_cnt, 1);
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        got_q.delete();
        run_impulse();
        check_impulse("rerun");

        // saturation, both rails
        for (int i = 0; i < NUM_COEF; i++) coef[i] = 16'sh7fff;
        do_reset();
        got_q.delete();
        repeat (16) send(32767);
        wait_drain();
        check("sat_pos_cnt", got_q.size(), 32);
        foreach (got_q[i]) check("sat_pos", got_q[i], 32767);
        do_reset();
        got_q.delete();
        repeat (16) send(-32768);
        wait_drain();
        check("sat_neg_cnt", got_q.size(), 32);
        foreach (got_q[i]) check("sat_neg", got_q[i], -32768);

        // rounding around the half-LSB point
        for (int i = 0; i < NUM_COEF; i++) coef[i] = '0;
        coef[0] = 16'sd1;
        rexp = '{1, 0, 0, 0, -1, 0};
        do_reset();
        got_q.delete();
        send(8192);
        send(8191);
        send(-8193);
        wait_drain();
        check("rnd_cnt", got_q.size(), 6);
        foreach (got_q[i]) if (i < 6) check("rnd", got_q[i], rexp[i]);

        // random coefficients, samples, gaps and output backpressure
        for (int i = 0; i < NUM_COEF; i++) coef[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
        do_reset();
        ready_mode = 1;
        repeat (40) begin
            r = 16'($urandom);
            send(int'(r));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain();
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_interpolator_x2.md
FIR_INTERPOLATOR_X2 -- requirements
Module: fir_interpolator_x2

Interface
REQ-001 SHALL have parameter NUM_COEF, default 32, total prototype taps; even values only, and TAPS = NUM_COEF/2.
REQ-002 SHALL have port clk, input, 1, the only clock; all logic on posedge clk.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sample_in, input, shortint, 16-bit signed input sample at the base rate.
REQ-005 SHALL have port in_valid, input, 1, sample_in valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-007 SHALL have port coef, input, shortint[NUM_COEF], prototype low-pass taps; static during operation.
REQ-008 SHALL have port sample_out, output, shortint, 16-bit signed interpolated sample at 2x rate.
REQ-009 SHALL have port out_valid, output, 1, sample_out valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts sample_out.

Function
REQ-011 SHALL perform 2x polyphase interpolation: for each accepted input, emit two outputs, phase 0 then phase 1.
REQ-012 SHALL keep delay line x[0..TAPS-1], with x[0] newest; on input accept, x[0]<=sample_in and x[k]<=x[k-1].
REQ-013 SHALL compute phase p output as sum over k=0..TAPS-1 of coef[2k+p]*x[k].
REQ-014 SHALL use a single serial multiplier: one product accumulated per cycle.
REQ-015 SHALL use a signed accumulator of at least 40 bits, so no internal overflow for any input or coef.
REQ-016 SHALL scale with round-half-up then shift: y = (acc + 8192) >>> 14, i.e. gain 2 to offset zero-stuffing.
REQ-017 SHALL saturate y to [-32768, 32767]; wrap-around is forbidden.
REQ-018 SHALL implement FSM states IDLE, MAC, ROUND, OUT.
REQ-019 IDLE: in_ready=1; in_valid&&in_ready at an edge shifts the delay line, sets phase=0, k=0, acc=0, and moves to MAC.
REQ-020 MAC: add coef[2k+phase]*x[k] each cycle; move to ROUND after k=TAPS-1.
REQ-021 ROUND: register sample_out from the saturated y, set out_valid=1, move to OUT.
REQ-022 OUT: hold sample_out and out_valid stable until out_valid&&out_ready.
REQ-023 On the OUT handshake with phase=0, SHALL set phase=1, k=0, acc=0, out_valid=0, and return to MAC.
REQ-024 On the OUT handshake with phase=1, SHALL set out_valid=0 and go to IDLE.
REQ-025 out_valid SHALL first be high TAPS+2 edges after the input-accept edge (18 at default).
REQ-026 Phase-1 out_valid SHALL rise TAPS+2 edges after the phase-0 handshake edge.
REQ-027 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored, with no shift and no state change.
REQ-028 out_ready SHALL be ignored while out_valid=0.
REQ-029 in_ready SHALL be a registered/state decode with no combinational path from out_ready.
REQ-030 At most one sample SHALL be in flight; no input FIFO.

Reset
REQ-031 While rst=1 at an edge: state IDLE, in_ready=1, out_valid=0, sample_out=0, acc=0, phase=0, k=0, all x[k]=0.
REQ-032 rst SHALL take priority over every handshake, including mid-MAC and mid-OUT.
REQ-033 After reset, no stale output SHALL be emitted; the first output corresponds to the first input accepted after reset.

Verification
REQ-034 Reset: after rst pulse -> in_ready=1, out_valid=0, sample_out=0; holding out_ready=1 for 100 cycles gives no output.
REQ-035 Impulse: coef[i]=i+1 (1..32), input 16384 then 15 zeros, out_ready=1 -> outputs 1,2,3,...,32 in order, then 0s.
REQ-036 Saturation: all coef=32767, constant input 32767 -> outputs 32767; constant -32768 -> outputs -32768; no wrap.
REQ-037 Rounding: coef[0]=1, others 0, input 8192 -> 1; input 8191 -> 0; input -8193 -> -1.
REQ-038 Backpressure: out_ready=0 for 10 cycles during OUT -> out_valid and sample_out stable, in_ready=0, in_valid pulses ignored; the sequence matches REQ-035.
REQ-039 Reset mid-MAC: assert rst during phase-1 MAC -> next edge idle state per REQ-031; rerunning REQ-035 gives an identical sequence.
